// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one Wishbone master; data wins ties.
// Latency: Wishbone cycle starts one clock after an eligible request; ready pulses one clock after ack/timeout.
// Backpressure: requesters hold req until ready; a port is ineligible during its own ready cycle.
module mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    if_req,
   input  logic [ADDR_WIDTH-1:0]   if_addr,
   output logic [DATA_WIDTH-1:0]   if_rdata,
   output logic                    if_ready,
   output logic                    if_err,
   input  logic                    mem_req,
   input  logic                    mem_we,
   input  logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [DATA_WIDTH-1:0]   mem_wdata,
   input  logic [DATA_WIDTH/8-1:0] mem_sel,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    mem_ready,
   output logic                    mem_err,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   output logic                    im,
   output logic                    mem
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUS  = 2'd1,
      MEM_BUS = 2'd2
   } state_t;

   // Counter value at which the current bus cycle is the last one allowed.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] tmo_cnt;
   logic       mem_elig;
   logic       if_elig;
   logic       start_mem;
   logic       start_if;
   logic       bus_ack;
   logic       bus_tmo;

   // A port is blocked during its own ready cycle so a still-held req is not reissued.
   assign mem_elig = mem_req & ~mem_ready;
   assign if_elig  = if_req & ~if_ready;

   // Busy indications toward the stall controller.
   assign im  = if_req & ~if_ready;
   assign mem = mem_req & ~mem_ready;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state and per-cycle control strobes; ack beats timeout in the same cycle.
   always_comb begin
      state_nxt = state;
      start_mem = 1'b0;
      start_if  = 1'b0;
      bus_ack   = 1'b0;
      bus_tmo   = 1'b0;
      case (state)
         IDLE: begin
            if (mem_elig) begin
               start_mem = 1'b1;
               state_nxt = MEM_BUS;
            end else if (if_elig) begin
               start_if  = 1'b1;
               state_nxt = IF_BUS;
            end
         end
         IF_BUS, MEM_BUS: begin
            if (wb_ack_i) begin
               bus_ack   = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_cnt == TMO_LAST) begin
               bus_tmo   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Wishbone master registers: loaded on acceptance, frozen until the cycle ends.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_sel_o <= '0;
      end else if (start_mem) begin
         wb_cyc_o <= 1'b1;
         wb_stb_o <= 1'b1;
         wb_we_o  <= mem_we;
         wb_adr_o <= mem_addr;
         wb_dat_o <= mem_wdata;
         wb_sel_o <= mem_sel;
      end else if (start_if) begin
         wb_cyc_o <= 1'b1;
         wb_stb_o <= 1'b1;
         wb_we_o  <= 1'b0;
         wb_adr_o <= if_addr;
         wb_sel_o <= '1;
      end else if (bus_ack || bus_tmo) begin
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
      end
   end

   // Timeout counter: cleared on entry, counts bus cycles that pass without ack.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_cnt <= '0;
      end else if (start_mem || start_if) begin
         tmo_cnt <= '0;
      end else if (state != IDLE && !wb_ack_i) begin
         tmo_cnt <= tmo_cnt + 8'd1;
      end
   end

   // Completion pulses and read data capture; writes and timeouts leave rdata untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_ready  <= 1'b0;
         if_err    <= 1'b0;
         if_rdata  <= '0;
         mem_ready <= 1'b0;
         mem_err   <= 1'b0;
         mem_rdata <= '0;
      end else begin
         if_ready  <= (bus_ack || bus_tmo) && (state == IF_BUS);
         if_err    <= bus_tmo && (state == IF_BUS);
         mem_ready <= (bus_ack || bus_tmo) && (state == MEM_BUS);
         mem_err   <= bus_tmo && (state == MEM_BUS);
         if (bus_ack && state == IF_BUS)
            if_rdata <= wb_dat_i;
         if (bus_ack && state == MEM_BUS && !wb_we_o)
            mem_rdata <= wb_dat_i;
      end
   end

endmodule
